fp_addsub_rnd: RTL and testbench
================================

# fp_addsub_rnd

Parametrised floating-point add/subtract unit with round-to-nearest-even, guard/round/sticky tracking, and overflow/underflow/inexact flags. It works through one operation at a time using a multi-cycle shift-per-cycle FSM. Operations start with a toggle request and completion is signalled by a level ack. It is the next-generation replacement for the plain adder in the float datapath: it adds an `op` mode, correct rounding, saturation and status flags.

## Interface
- `EMSB`, default 7: exponent field MSB; the exponent field is EMSB+1 bits, with bias 2**EMSB.
- `FMSB`, default 22: stored fraction MSB; the fraction field is FMSB+1 bits, with an implicit leading 1.
- `clk` input, 1: clock; all state updates on the rising edge.
- `rstn` input, 1: reset. One clock; reset is asynchronous and active-low.
- `enable` input, 1: when low, the FSM is forced to IDLE and the datapath, `tx_data` and flags are cleared.
- `req` input, 1: request toggle; any change of level starts one operation.
- `ack` output, 1: high while in IDLE, i.e. ready and result valid.
- `op` input, 1: 0 = add, 1 = subtract (result = rx_data_1 − rx_data_2). Sampled in LOAD.
- `rx_data_1`, `rx_data_2` input, W = EMSB+FMSB+3: operands `{sign, expt field, frac}`. Sampled in LOAD.
- `tx_data` output, W: result, registered.
- `ovf`, `unf`, `inexact` output, 1 each: status of the last result; registered with `tx_data`.

## Operation
- Encoding: an exponent field of 0 means zero (fraction ignored). All other fields are normal. There is no inf/NaN; the all-ones field is ordinary.
- Internal datapath is sign-magnitude:
  - Mantissa register is `{carry, hidden, frac[FMSB:0], G, R, S}`.
  - Exponent is kept in EMSB+2 signed bits so overflow and underflow can be detected.
- `req_d` is registered every enabled cycle. `req_x = req ^ req_d`. A toggle seen outside IDLE is ignored and is not queued.
- States and transitions:
  - IDLE: on `req_x`, go to LOAD.
  - LOAD: capture the operands. For `op` = 1, invert the sign of operand 2. Go to CHECK.
  - CHECK: if either operand is zero, the result is the other operand (both zero: +0), with flags cleared; go to TX. Otherwise, if the exponents differ, go to ALIGN; else go to ADD.
  - ALIGN: shift the smaller operand right by 1 and increment its exponent, OR-ing the bits shifted out into S. After `min(|Δe|, FMSB+4)` cycles, go to ADD. Beyond the cap, the mantissa is zero with S = 1.
  - ADD:
    - Equal signs: add the magnitudes.
    - Otherwise: subtract the smaller magnitude from the larger; the result takes the larger operand's sign.
    - Zero magnitude: the result is +0; go to TX.
    - Otherwise go to NORM.
  - NORM, one shift per cycle:
    - If carry = 1: shift right 1 (sticky-preserving), exponent +1.
    - Else if hidden = 0: shift left 1, exponent −1.
    - Else go to ROUND.
  - ROUND:
    - Increment when `G & (R | S | lsb)`.
    - A mantissa carry-out renormalises by one right shift and exponent +1 in the same cycle.
    - `inexact = G | R | S`.
    - Go to TX.
  - TX: write `tx_data` and flags, then go to IDLE.
- Range:
  - Biased exponent > 2**(EMSB+1)−1: saturate to the max finite value with the result sign (field all ones, frac all ones). Set `ovf = 1` and `inexact = 1`.
  - Biased exponent ≤ 0: flush to signed zero (all field bits 0 except sign). Set `unf = 1` and `inexact = 1`.

## Timing
- Reset and `enable` low:
  - `ack` = 1.
  - `tx_data` = 0, `ovf` = `unf` = `inexact` = 0.
  - `req_d` = 0 on reset; `req_d` holds while `enable` is low.
- Edge numbering is from the edge that samples the toggle (edge 1, enters LOAD). A = alignment shifts, N = normalisation shifts.
  - Normal path: CHECK at edge 2, ADD at 3+A, ROUND at 4+A+N. `tx_data` and flags update at edge 5+A+N. `ack` rises at edge 6+A+N.
  - Zero path: `tx_data` updates at edge 3 and `ack` rises at edge 4.
  - Cancellation path (ADD gives zero): `tx_data` updates at edge 4+A and `ack` rises at 5+A.
- Worst-case latency is bounded by 6 + (FMSB+4) + (FMSB+3) cycles.
- `tx_data` and flags hold their values until the next TX, reset, or `enable` low.
- `rstn` asserted mid-operation: the operation is aborted immediately. A toggle made before the reset is not replayed.
- `enable` deasserted mid-operation: the operation is aborted at the next edge. A new toggle is required after re-enable.

## Test plan
Defaults EMSB = 7, FMSB = 22, bias 128; 1.0 = 0x40000000.
- 0x40000000 + 0x40000000, `op` = 0 → `tx_data` = 0x40800000; flags 0; A = 0, N = 1, so `ack` rises at edge 7.
- 0x40000000 + 0x40800000 → 0x40C00000; A = 1, N = 0, so `ack` rises at edge 7. Swapping the operands gives the same result and latency.
- 0x40C00000 − 0x40C00000, `op` = 1 → 0x00000000; flags 0; `ack` rises at edge 5. Also 0x00000000 + 0xC0800000 → 0xC0800000, with `ack` at edge 4.
- 0x40000000 + 0x34000000 (2^-24, a halfway tie) → 0x40000000 with `inexact` = 1. Then 0x40000001 + 0x34000000 → 0x40000002 with `inexact` = 1 (tie rounds to even).
- 0x7FFFFFFF + 0x7FFFFFFF → 0x7FFFFFFF with `ovf` = 1 and `inexact` = 1. Also 0x00800000 − 0x00C00000 → 0x80000000 with `unf` = 1.
- Mid-operation events:
  - `rstn` pulsed low during ALIGN → `ack` = 1 and `tx_data` = 0 asynchronously.
  - `req` toggled twice while busy → exactly one operation completes.
  - `enable` low for 1 cycle → IDLE with outputs cleared.

Source files
------------

// File: rtl/fp_addsub_rnd.sv
// Multi-cycle sign-magnitude floating-point add/subtract with round-to-nearest-even,
// max-finite saturation, flush-to-zero and ovf/unf/inexact status; one shift per cycle.
module fp_addsub_rnd #(
  parameter int EMSB = 7,
  parameter int FMSB = 22
) (
  input  logic                 clk,
  input  logic                 rstn,
  input  logic                 enable,
  input  logic                 req,
  output logic                 ack,
  input  logic                 op,
  input  logic [EMSB+FMSB+2:0] rx_data_1,
  input  logic [EMSB+FMSB+2:0] rx_data_2,
  output logic [EMSB+FMSB+2:0] tx_data,
  output logic                 ovf,
  output logic                 unf,
  output logic                 inexact
);
  localparam int W   = EMSB + FMSB + 3;
  localparam int MW  = FMSB + 6;
  localparam int EW  = EMSB + 2;
  localparam int CAP = FMSB + 4;
  localparam int CW  = $clog2(CAP + 1);
  localparam logic signed [EW-1:0] BIAS = EW'(2**EMSB);
  localparam logic signed [EW-1:0] ONE  = EW'(1);

  typedef enum logic [2:0] {IDLE, LOAD, CHECK, ALIGN, ADD, NORM, ROUND, TX} state_t;

  state_t               state_q, state_d;
  logic                 req_d_q, req_d_d, req_x;
  logic                 ack_q, ack_d;
  logic [W-1:0]         tx_q, tx_d;
  logic                 ovf_q, ovf_d, unf_q, unf_d, inx_q, inx_d;
  logic                 sa_q, sa_d, sb_q, sb_d, za_q, za_d, zb_q, zb_d;
  logic signed [EW-1:0] ea_q, ea_d, eb_q, eb_d, en;
  logic [MW-1:0]        ma_q, ma_d, mb_q, mb_d, sum, mn;
  logic                 ssum;
  logic [CW-1:0]        cnt_q, cnt_d;

  // Exponents are held unbiased so that one extra bit covers both overflow and underflow.
  function automatic logic signed [EW-1:0] to_exp(input logic [EMSB:0] f);
    return $signed({1'b0, f}) - BIAS;
  endfunction

  function automatic logic [MW-1:0] sh_r1(input logic [MW-1:0] m);
    return {1'b0, m[MW-1:2], m[1] | m[0]};
  endfunction

  function automatic logic [CW-1:0] align_count(input logic signed [EW-1:0] a,
                                                input logic signed [EW-1:0] b);
    logic signed [EW:0] d;
    d = $signed({a[EW-1], a}) - $signed({b[EW-1], b});
    if (d < 0) d = -d;
    if (d > CAP) return CW'(CAP);
    return CW'(d);
  endfunction

  // Round to nearest even, then range-check; returns {result, ovf, unf, inexact}.
  function automatic logic [W+2:0] finish(input logic s, input logic signed [EW-1:0] e,
                                          input logic [MW-1:0] m);
    logic                 inc;
    logic [FMSB+2:0]      r;
    logic signed [EW-1:0] e2;
    logic signed [EW:0]   eb;
    inc = m[2] & (m[1] | m[0] | m[3]);
    r   = m[MW-1:3] + {{(FMSB+2){1'b0}}, inc};
    e2  = e;
    if (r[FMSB+2]) begin
      r  = r >> 1;
      e2 = e + ONE;
    end
    eb = $signed({e2[EW-1], e2}) + $signed({1'b0, BIAS});
    if (!eb[EW] && eb[EW-1])
      return {s, {(W-1){1'b1}}, 3'b101};
    if (eb[EW] || eb == '0)
      return {s, {(W-1){1'b0}}, 3'b011};
    return {s, eb[EMSB:0], r[FMSB:0], 2'b00, |m[2:0]};
  endfunction

  assign req_x = req ^ req_d_q;

  always_comb begin
    state_d = state_q;
    req_d_d = req_d_q;
    sa_d = sa_q; sb_d = sb_q; za_d = za_q; zb_d = zb_q;
    ea_d = ea_q; eb_d = eb_q; ma_d = ma_q; mb_d = mb_q; cnt_d = cnt_q;
    tx_d = tx_q; ovf_d = ovf_q; unf_d = unf_q; inx_d = inx_q;
    sum = '0; ssum = 1'b0; mn = '0; en = '0;
    if (!enable) begin
      state_d = IDLE;
      sa_d = 1'b0; sb_d = 1'b0; za_d = 1'b0; zb_d = 1'b0;
      ea_d = '0; eb_d = '0; ma_d = '0; mb_d = '0; cnt_d = '0;
      tx_d = '0; ovf_d = 1'b0; unf_d = 1'b0; inx_d = 1'b0;
    end else begin
      req_d_d = req;
      case (state_q)
        IDLE: if (req_x) state_d = LOAD;
        LOAD: begin
          sa_d = rx_data_1[W-1];
          sb_d = rx_data_2[W-1] ^ op;
          za_d = (rx_data_1[W-2:FMSB+1] == '0);
          zb_d = (rx_data_2[W-2:FMSB+1] == '0);
          ea_d = to_exp(rx_data_1[W-2:FMSB+1]);
          eb_d = to_exp(rx_data_2[W-2:FMSB+1]);
          ma_d = {2'b01, rx_data_1[FMSB:0], 3'b000};
          mb_d = {2'b01, rx_data_2[FMSB:0], 3'b000};
          state_d = CHECK;
        end
        CHECK: begin
          if (za_q || zb_q) begin
            if (za_q && zb_q) begin
              tx_d = '0; ovf_d = 1'b0; unf_d = 1'b0; inx_d = 1'b0;
            end else if (za_q) begin
              {tx_d, ovf_d, unf_d, inx_d} = finish(sb_q, eb_q, mb_q);
            end else begin
              {tx_d, ovf_d, unf_d, inx_d} = finish(sa_q, ea_q, ma_q);
            end
            state_d = TX;
          end else if (ea_q != eb_q) begin
            cnt_d   = align_count(ea_q, eb_q);
            state_d = ALIGN;
          end else begin
            state_d = ADD;
          end
        end
        ALIGN: begin
          if (ea_q < eb_q) begin
            ma_d = sh_r1(ma_q);
            ea_d = ea_q + ONE;
          end else begin
            mb_d = sh_r1(mb_q);
            eb_d = eb_q + ONE;
          end
          cnt_d = cnt_q - CW'(1);
          if (cnt_q == CW'(1)) state_d = ADD;
        end
        ADD: begin
          if (sa_q == sb_q) begin
            sum = ma_q + mb_q; ssum = sa_q;
          end else if (ma_q >= mb_q) begin
            sum = ma_q - mb_q; ssum = sa_q;
          end else begin
            sum = mb_q - ma_q; ssum = sb_q;
          end
          // A capped alignment leaves the smaller exponent behind; the larger one rules.
          ea_d = (ea_q >= eb_q) ? ea_q : eb_q;
          if (sum == '0) begin
            tx_d = '0; ovf_d = 1'b0; unf_d = 1'b0; inx_d = 1'b0;
            state_d = TX;
          end else begin
            ma_d = sum;
            sa_d = ssum;
            state_d = (sum[MW-1] || !sum[MW-2]) ? NORM : ROUND;
          end
        end
        NORM: begin
          if (ma_q[MW-1]) begin
            mn = sh_r1(ma_q);
            en = ea_q + ONE;
          end else begin
            mn = ma_q << 1;
            en = ea_q - ONE;
          end
          ma_d = mn;
          ea_d = en;
          if (!mn[MW-1] && mn[MW-2]) state_d = ROUND;
        end
        ROUND: begin
          {tx_d, ovf_d, unf_d, inx_d} = finish(sa_q, ea_q, ma_q);
          state_d = TX;
        end
        TX:      state_d = IDLE;
        default: state_d = IDLE;
      endcase
    end
    ack_d = (state_d == IDLE);
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state_q <= IDLE;
      req_d_q <= 1'b0;
      ack_q   <= 1'b1;
      tx_q    <= '0;
      ovf_q   <= 1'b0;
      unf_q   <= 1'b0;
      inx_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      req_d_q <= req_d_d;
      ack_q   <= ack_d;
      tx_q    <= tx_d;
      ovf_q   <= ovf_d;
      unf_q   <= unf_d;
      inx_q   <= inx_d;
    end
  end

  always_ff @(posedge clk) begin
    sa_q  <= sa_d;
    sb_q  <= sb_d;
    za_q  <= za_d;
    zb_q  <= zb_d;
    ea_q  <= ea_d;
    eb_q  <= eb_d;
    ma_q  <= ma_d;
    mb_q  <= mb_d;
    cnt_q <= cnt_d;
  end

  assign ack     = ack_q;
  assign tx_data = tx_q;
  assign ovf     = ovf_q;
  assign unf     = unf_q;
  assign inexact = inx_q;
endmodule

// File: tb/tb_fp_addsub_rnd.sv
// Bench for fp_addsub_rnd: vector table through a scoreboard queue, plus
// hand-written reset, enable and double-toggle sequences.
`timescale 1ns/1ps
module tb_fp_addsub_rnd;
  localparam int EMSB = 7;
  localparam int FMSB = 22;
  localparam int W    = EMSB + FMSB + 3;
  localparam int TMO  = 200;

  typedef struct {
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic         sub;
    logic [W-1:0] res;
    logic [2:0]   flg;  // {ovf, unf, inexact}
    int           lat;  // edge at which ack rises, counted from the toggle-sampling edge
  } vec_t;

  logic         clk = 1'b0, rstn = 1'b0, enable = 1'b0, req = 1'b0, op = 1'b0;
  logic [W-1:0] rx_data_1 = '0, rx_data_2 = '0;
  logic         ack, ovf, unf, inexact;
  logic [W-1:0] tx_data;
  int           n_cmp = 0, n_bad = 0;
  vec_t         tbl[$];
  vec_t         sb[$];

  fp_addsub_rnd #(.EMSB(EMSB), .FMSB(FMSB)) dut (
    .clk(clk), .rstn(rstn), .enable(enable), .req(req), .ack(ack), .op(op),
    .rx_data_1(rx_data_1), .rx_data_2(rx_data_2), .tx_data(tx_data),
    .ovf(ovf), .unf(unf), .inexact(inexact)
  );

  always #5 clk = ~clk;

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  function automatic vec_t mk(input logic [W-1:0] a, input logic [W-1:0] b, input logic sub,
                              input logic [W-1:0] res, input logic [2:0] flg, input int lat);
    vec_t v;
    v.a = a; v.b = b; v.sub = sub; v.res = res; v.flg = flg; v.lat = lat;
    return v;
  endfunction

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Drives one operation; t1/t2 are edges after which req is toggled again (0 = never).
  task automatic run_op(input vec_t v, input string name, input int t1, input int t2);
    vec_t e;
    int   k;
    bit   done;
    rx_data_1 = v.a;
    rx_data_2 = v.b;
    op        = v.sub;
    sb.push_back(v);
    req  = ~req;
    k    = 0;
    done = 1'b0;
    while (!done && k < TMO) begin
      @(posedge clk); #1;
      k++;
      if (k == t1 || k == t2) req = ~req;
      if (ack) done = 1'b1;
    end
    if (!done) begin
      n_cmp++; n_bad++;
      $display("FAIL %s timeout: ack still low after %0d edges", name, k);
    end
    if (sb.size() == 0) begin
      n_cmp++; n_bad++;
      $display("FAIL %s scoreboard: no expected entry", name);
    end else begin
      e = sb.pop_front();
      check({name, " result"}, 64'({tx_data, ovf, unf, inexact}), 64'({e.res, e.flg}));
      check({name, " ack edge"}, 64'(k), 64'(e.lat));
    end
  endtask

  task automatic hold_idle(input string name, input int cycles);
    bit stay;
    stay = 1'b1;
    repeat (cycles) begin
      @(posedge clk); #1;
      if (!ack) stay = 1'b0;
    end
    check(name, 64'(stay), 64'(1));
  endtask

  initial begin
    tbl.push_back(mk(32'h40000000, 32'h40000000, 1'b0, 32'h40800000, 3'b000, 7));
    tbl.push_back(mk(32'h40000000, 32'h40800000, 1'b0, 32'h40C00000, 3'b000, 7));
    tbl.push_back(mk(32'h40800000, 32'h40000000, 1'b0, 32'h40C00000, 3'b000, 7));
    tbl.push_back(mk(32'h40C00000, 32'h40C00000, 1'b1, 32'h00000000, 3'b000, 5));
    tbl.push_back(mk(32'h00000000, 32'hC0800000, 1'b0, 32'hC0800000, 3'b000, 4));
    tbl.push_back(mk(32'h40000000, 32'h34000000, 1'b0, 32'h40000000, 3'b001, 30));
    tbl.push_back(mk(32'h40000001, 32'h34000000, 1'b0, 32'h40000002, 3'b001, 30));
    tbl.push_back(mk(32'h7FFFFFFF, 32'h7FFFFFFF, 1'b0, 32'h7FFFFFFF, 3'b101, 7));
    tbl.push_back(mk(32'h00800000, 32'h00C00000, 1'b1, 32'h80000000, 3'b011, 7));
    tbl.push_back(mk(32'hC0000000, 32'hC0000000, 1'b0, 32'hC0800000, 3'b000, 7));
    tbl.push_back(mk(32'h40800000, 32'h40000000, 1'b1, 32'h40000000, 3'b000, 8));
    tbl.push_back(mk(32'h40000000, 32'h20000000, 1'b0, 32'h40000000, 3'b001, 32));
    tbl.push_back(mk(32'h40000000, 32'h20000000, 1'b1, 32'h40000000, 3'b001, 33));
    tbl.push_back(mk(32'h00000000, 32'h00000000, 1'b0, 32'h00000000, 3'b000, 4));
    tbl.push_back(mk(32'h00000000, 32'h40000000, 1'b1, 32'hC0000000, 3'b000, 4));
    tbl.push_back(mk(32'h40000000, 32'h00000000, 1'b1, 32'h40000000, 3'b000, 4));
    tbl.push_back(mk(32'h00123456, 32'h40400000, 1'b0, 32'h40400000, 3'b000, 4));
    tbl.push_back(mk(32'h00800000, 32'h00800000, 1'b0, 32'h01000000, 3'b000, 7));
    tbl.push_back(mk(32'h7F800000, 32'h7F800000, 1'b0, 32'h7FFFFFFF, 3'b101, 7));
    tbl.push_back(mk(32'h40000000, 32'h34400000, 1'b0, 32'h40000001, 3'b001, 30));
    tbl.push_back(mk(32'h40000000, 32'h33800000, 1'b0, 32'h40000000, 3'b001, 31));
    tbl.push_back(mk(32'h40000000, 32'h40800000, 1'b1, 32'hC0000000, 3'b000, 8));

    enable = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    check("reset outputs", 64'({ack, tx_data, ovf, unf, inexact}), 64'({1'b1, 35'h0}));
    rstn = 1'b1;
    @(posedge clk); #1;

    foreach (tbl[i]) run_op(tbl[i], $sformatf("vec%0d", i), 0, 0);

    // Asynchronous reset during ALIGN; the toggle is arranged to leave req low.
    if (req == 1'b0) run_op(tbl[0], "pre_reset", 0, 0);
    rx_data_1 = 32'h40000000;
    rx_data_2 = 32'h34000000;
    op        = 1'b0;
    req       = ~req;
    repeat (5) @(posedge clk);
    #1;
    check("busy before reset", 64'(ack), 64'(0));
    #2 rstn = 1'b0;
    #1;
    check("async reset outputs", 64'({ack, tx_data, ovf, unf, inexact}), 64'({1'b1, 35'h0}));
    @(posedge clk); #1;
    rstn = 1'b1;
    hold_idle("no replay after reset", 12);
    check("tx after reset", 64'(tx_data), 64'(0));

    // Two toggles while busy: exactly one operation.
    run_op(tbl[0], "double toggle", 2, 3);
    hold_idle("no second op", 12);
    check("tx held", 64'(tx_data), 64'(32'h40800000));

    // One-cycle enable drop mid-operation.
    rx_data_1 = 32'h40000000;
    rx_data_2 = 32'h34000000;
    op        = 1'b0;
    req       = ~req;
    repeat (3) @(posedge clk);
    #1;
    check("busy before disable", 64'(ack), 64'(0));
    enable = 1'b0;
    @(posedge clk); #1;
    check("disable outputs", 64'({ack, tx_data, ovf, unf, inexact}), 64'({1'b1, 35'h0}));
    enable = 1'b1;
    hold_idle("idle after re-enable", 10);
    run_op(tbl[10], "after re-enable", 0, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
